// File: rtl/rf_addr_scheduler.sv
// Walks (h, w, s) output positions of one conv layer, kicking the RF address generator per position
// and offering each finished RF block to the PE array. Optional watchdog: `RF_SCHED_TIMEOUT_EN.
module rf_addr_scheduler #(
  parameter int unsigned IA_ROW      = 16,
  parameter int unsigned S_MAX       = 3,
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_start,
  input  logic [$clog2(IA_ROW):0]      i_h_size,
  input  logic [$clog2(IA_ROW):0]      i_w_size,
  input  logic [$clog2(S_MAX+1)-1:0]   i_s_num,
  output logic                         o_ag_start,
  output logic [$clog2(IA_ROW):0]      o_ag_h,
  output logic [$clog2(IA_ROW):0]      o_ag_w,
  output logic [$clog2(S_MAX+1)-1:0]   o_ag_s,
  input  logic                         i_ag_finish,
  output logic                         o_pe_valid,
  input  logic                         i_pe_ready,
  output logic                         o_busy,
  output logic                         o_done,
  output logic                         o_err
);

  localparam int unsigned CW = $clog2(IA_ROW) + 1;
  localparam int unsigned SW = $clog2(S_MAX + 1);

  if (S_MAX == 0 || TIMEOUT_CYC == 0) begin : g_param_check
    $error("rf_addr_scheduler: S_MAX and TIMEOUT_CYC must be non-zero");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_HAND  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] h_q, w_q, h_size_q, w_size_q;
  logic [SW-1:0] s_q, s_num_q;
  logic          start_acc_c, hs_c, s_last_c, w_last_c, h_last_c, timeout_c;
  logic          ag_start_d, pe_valid_d, busy_d, done_d;

  assign start_acc_c = (state_q == S_IDLE) && i_start;
  assign hs_c        = (state_q == S_HAND) && i_pe_ready;
  assign s_last_c    = (s_q == s_num_q);
  assign w_last_c    = (w_q == w_size_q - CW'(1));
  assign h_last_c    = (h_q == h_size_q - CW'(1));

`ifdef RF_SCHED_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] wait_cnt_q;
  logic          err_q;

  // wait_cnt_q holds the number of S_WAIT cycles already spent; restarts on every entry
  assign timeout_c = (state_q == S_WAIT) && !i_ag_finish && (wait_cnt_q == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      wait_cnt_q <= (state_q == S_WAIT) ? wait_cnt_q + TW'(1) : '0;
      if (start_acc_c) begin
        err_q <= 1'b0;
      end else if (timeout_c) begin
        err_q <= 1'b1;
      end
    end
  end

  assign o_err = err_q;
`else
  assign timeout_c = 1'b0;
  assign o_err     = 1'b0;
`endif

  // State register plus registered Moore outputs decoded from the next state
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      o_ag_start <= 1'b0;
      o_pe_valid <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      state_q    <= state_d;
      o_ag_start <= ag_start_d;
      o_pe_valid <= pe_valid_d;
      o_busy     <= busy_d;
      o_done     <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = (i_h_size == '0 || i_w_size == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: state_d = i_ag_finish ? S_HAND : S_WAIT;
      S_WAIT: begin
        if (i_ag_finish) begin
          state_d = S_HAND;
        end else if (timeout_c) begin
          state_d = S_IDLE;
        end
      end
      S_HAND: begin
        if (i_pe_ready) begin
          state_d = (h_last_c && w_last_c && s_last_c) ? S_DONE : S_ISSUE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ag_start_d = 1'b0;
    pe_valid_d = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    if (state_d == S_ISSUE) ag_start_d = 1'b1;
    if (state_d == S_HAND)  pe_valid_d = 1'b1;
    if (state_d != S_IDLE)  busy_d     = 1'b1;
    if (state_d == S_DONE)  done_d     = 1'b1;
  end

  // Config latch and position counters; s innermost, then w, then h
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      h_size_q <= '0;
      w_size_q <= '0;
      s_num_q  <= '0;
      h_q      <= '0;
      w_q      <= '0;
      s_q      <= '0;
    end else if (start_acc_c) begin
      h_size_q <= i_h_size;
      w_size_q <= i_w_size;
      s_num_q  <= i_s_num;
      h_q      <= '0;
      w_q      <= '0;
      s_q      <= '0;
    end else if (hs_c) begin
      if (s_last_c) begin
        s_q <= '0;
        if (w_last_c) begin
          w_q <= '0;
          h_q <= h_q + CW'(1);
        end else begin
          w_q <= w_q + CW'(1);
        end
      end else begin
        s_q <= s_q + SW'(1);
      end
    end
  end

  assign o_ag_h = h_q;
  assign o_ag_w = w_q;
  assign o_ag_s = s_q;

endmodule

// File: tb/tb_rf_addr_scheduler.sv
// Self-checking bench for rf_addr_scheduler: directed scenarios plus randomized layers
// checked against a position-list / handshake-protocol reference model.
module tb_rf_addr_scheduler;

  localparam int unsigned IA_ROW = 16;
  localparam int unsigned CW     = $clog2(IA_ROW) + 1;
  localparam int unsigned PW     = 2 * CW + 2;
`ifdef RF_SCHED_TIMEOUT_EN
  localparam int unsigned TO_CYC = 8;
`else
  localparam int unsigned TO_CYC = 256;
`endif

  logic          clk, rst_n, start, ag_finish, pe_ready;
  logic [CW-1:0] h_size, w_size, ag_h, ag_w;
  logic [1:0]    s_num, ag_s;
  logic          ag_start, pe_valid, busy, done, err;

  int n_chk = 0;
  int n_err = 0;

  rf_addr_scheduler #(.IA_ROW(IA_ROW), .S_MAX(3), .TIMEOUT_CYC(TO_CYC)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
    .i_h_size(h_size), .i_w_size(w_size), .i_s_num(s_num),
    .o_ag_start(ag_start), .o_ag_h(ag_h), .o_ag_w(ag_w), .o_ag_s(ag_s),
    .i_ag_finish(ag_finish), .o_pe_valid(pe_valid), .i_pe_ready(pe_ready),
    .o_busy(busy), .o_done(done), .o_err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs a full layer; the model is the ordered list of positions plus the protocol rules
  task automatic run_layer(input int h, input int w, input int sn, input int fin_d,
                           input int rdy_pct, input int hold_n);
    logic [PW-1:0] q[$];
    int  total, fin_cnt, vcnt, hs, starts, d, cyc;
    bit  last_hs, exp_start, exp_valid, next_valid, done_seen;
    for (int hh = 0; hh < h; hh++)
      for (int ww = 0; ww < w; ww++)
        for (int ss = 0; ss <= sn; ss++)
          q.push_back({CW'(hh), CW'(ww), 2'(ss)});
    total = h * w * (sn + 1);
    h_size = CW'(h); w_size = CW'(w); s_num = 2'(sn);
    start = 1'b1;
    step();
    start = 1'b0;
    h_size = CW'($urandom_range(0, 15));
    w_size = CW'($urandom_range(0, 15));
    s_num  = 2'($urandom_range(0, 3));
    fin_cnt = 0; vcnt = 0; hs = 0; starts = 0;
    last_hs = 1'b0; exp_start = 1'b1; exp_valid = 1'b0; done_seen = 1'b0;
    cyc = 0;
    while (cyc < 3000) begin
      cyc++;
      chk("err_low", 32'(err), 32'd0);
      if (last_hs) begin
        chk("done_after_last_hs", 32'(done), 32'd1);
        chk("busy_in_done", 32'(busy), 32'd1);
        chk("no_start_in_done", 32'(ag_start), 32'd0);
        chk("no_valid_in_done", 32'(pe_valid), 32'd0);
        chk("handshake_count", 32'(hs), 32'(total));
        chk("ag_start_count", 32'(starts), 32'(total));
        done_seen = 1'b1;
        step();
        break;
      end
      chk("done_low", 32'(done), 32'd0);
      chk("busy_high", 32'(busy), 32'd1);
      chk("ag_start", 32'(ag_start), 32'(exp_start));
      chk("pe_valid", 32'(pe_valid), 32'(exp_valid));
      chk("coords", 32'({ag_h, ag_w, ag_s}), 32'(q[0]));
      if (ag_start) starts++;
      ag_finish = 1'b0;
      if (fin_cnt > 0) begin
        fin_cnt--;
        if (fin_cnt == 0) ag_finish = 1'b1;
      end
      if (exp_start) begin
        d = (fin_d < 0) ? int'($urandom_range(0, 3)) : fin_d;
        if (d == 0) ag_finish = 1'b1;
        else fin_cnt = d;
      end
      if (exp_valid) begin
        vcnt++;
        pe_ready = (vcnt > hold_n) && (int'($urandom_range(1, 100)) <= rdy_pct);
      end else begin
        pe_ready = 1'($urandom_range(0, 1));
      end
      exp_start  = 1'b0;
      next_valid = exp_valid;
      if (ag_finish) next_valid = 1'b1;
      if (exp_valid && pe_ready) begin
        if (rdy_pct == 100) chk("valid_hold_len", 32'(vcnt), 32'(hold_n + 1));
        vcnt = 0;
        hs++;
        void'(q.pop_front());
        next_valid = 1'b0;
        if (q.size() == 0) last_hs = 1'b1;
        else exp_start = 1'b1;
      end
      exp_valid = next_valid;
      step();
    end
    chk("layer_completed", 32'(done_seen), 32'd1);
    chk("idle_done_low", 32'(done), 32'd0);
    chk("idle_busy_low", 32'(busy), 32'd0);
    ag_finish = 1'b0;
    pe_ready  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; ag_finish = 1'b0; pe_ready = 1'b0;
    h_size = '0; w_size = '0; s_num = '0;
    step(); step();
    chk("rst_ag_start", 32'(ag_start), 32'd0);
    chk("rst_coords", 32'({ag_h, ag_w, ag_s}), 32'd0);
    chk("rst_pe_valid", 32'(pe_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    step();

    // Directed layers: 2x2 fixed finish delay, 1x1 with three sub-positions, backpressure
    run_layer(2, 2, 0, 3, 100, 0);
    run_layer(1, 1, 2, 1, 100, 0);
    run_layer(1, 2, 0, 1, 100, 5);

    // Zero-size layers go straight to done
    h_size = '0; w_size = CW'(3); s_num = '0;
    start = 1'b1; step(); start = 1'b0;
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_busy", 32'(busy), 32'd1);
    chk("zero_no_start", 32'(ag_start), 32'd0);
    step();
    chk("zero_done_end", 32'(done), 32'd0);
    chk("zero_busy_end", 32'(busy), 32'd0);
    chk("zero_no_start2", 32'(ag_start), 32'd0);
    h_size = CW'(2); w_size = '0;
    start = 1'b1; step(); start = 1'b0;
    chk("zero_w_done", 32'(done), 32'd1);
    step();

    // Start while busy is ignored; async reset in S_WAIT clears everything without done
    h_size = CW'(2); w_size = CW'(2); s_num = 2'd1;
    start = 1'b1; step(); start = 1'b0;
    chk("rw_issue", 32'(ag_start), 32'd1);
    step();
    chk("rw_wait_start", 32'(ag_start), 32'd0);
    chk("rw_wait_busy", 32'(busy), 32'd1);
    h_size = '0; start = 1'b1; step(); start = 1'b0;
    chk("ign_start_busy", 32'(busy), 32'd1);
    chk("ign_start_done", 32'(done), 32'd0);
    chk("ign_start_ag", 32'(ag_start), 32'd0);
    chk("ign_start_valid", 32'(pe_valid), 32'd0);
    chk("ign_start_coords", 32'({ag_h, ag_w, ag_s}), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_all", 32'({ag_start, pe_valid, done, err, ag_h, ag_w, ag_s}), 32'd0);
    step();
    chk("rst_hold_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    step();
    chk("post_rst_done", 32'(done), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);
    step();

    // Finish that never comes
    h_size = CW'(1); w_size = CW'(1); s_num = '0;
    start = 1'b1; step(); start = 1'b0;
    chk("wd_issue", 32'(ag_start), 32'd1);
    for (int k = 0; k < int'(TO_CYC); k++) begin
      step();
      if (k == 0 || k == int'(TO_CYC) - 1) begin
        chk("wd_wait_busy", 32'(busy), 32'd1);
        chk("wd_wait_err", 32'(err), 32'd0);
      end
    end
    step();
`ifdef RF_SCHED_TIMEOUT_EN
    chk("wd_busy_low", 32'(busy), 32'd0);
    chk("wd_err_set", 32'(err), 32'd1);
    chk("wd_no_done", 32'(done), 32'd0);
    step(); step();
    chk("wd_err_sticky", 32'(err), 32'd1);
    run_layer(1, 1, 0, 2, 100, 0);
`else
    chk("nowd_still_busy", 32'(busy), 32'd1);
    chk("nowd_err_zero", 32'(err), 32'd0);
    ag_finish = 1'b1; step(); ag_finish = 1'b0;
    chk("nowd_valid", 32'(pe_valid), 32'd1);
    pe_ready = 1'b1; step(); pe_ready = 1'b0;
    chk("nowd_done", 32'(done), 32'd1);
    step();
    chk("nowd_idle", 32'(busy), 32'd0);
`endif

    // Randomized layers
    for (int r = 0; r < 8; r++) begin
      run_layer(int'($urandom_range(1, 4)), int'($urandom_range(1, 4)),
                int'($urandom_range(0, 3)), -1, 70, int'($urandom_range(0, 2)));
      repeat (int'($urandom_range(0, 2))) step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
